// File: rtl/lr3_disp_pkg.sv
// lr3_disp_pkg: shared constants, segment table and scan FSM states for the display driver.
// Rev 1.0
`default_nettype none

package lr3_disp_pkg;

  localparam int NDIG_DEF = 8;

  localparam logic [6:0]          CAT_OFF = 7'h7F;
  localparam logic [NDIG_DEF-1:0] AN_OFF  = '1;

  // Active-low segments, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {
    ST_ACT = 1'b0,
    ST_BLK = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lr3_disp_scan_if.sv
// lr3_disp_scan_if: scan tick, data load, display controls and pin outputs of the display driver.
// Rev 1.0
`default_nettype none

interface lr3_disp_scan_if #(
  parameter int NDIG = 8
);
  logic            disp_ce;
  logic            ld;
  logic [31:0]     dat_i;
  logic [NDIG-1:0] en_mask;
  logic            lzb;
  logic [6:0]      cat;
  logic [NDIG-1:0] an;
  logic [2:0]      dig_idx;
  logic            frm_o;

  modport master (
    output disp_ce, ld, dat_i, en_mask, lzb,
    input  cat, an, dig_idx, frm_o
  );

  modport slave (
    input  disp_ce, ld, dat_i, en_mask, lzb,
    output cat, an, dig_idx, frm_o
  );
endinterface

`default_nettype wire

// File: rtl/lr3_hex7seg.sv
// lr3_hex7seg: hex nibble to active-low 7-segment pattern.
// Rev 1.0
`default_nettype none

module lr3_hex7seg
  import lr3_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

`default_nettype wire

// File: rtl/lr3_disp_scan.sv
// lr3_disp_scan: double-buffered, blanking, time-multiplexed 7-segment scanner.
// Rev 1.0
`default_nettype none

module lr3_disp_scan
  import lr3_disp_pkg::*;
#(
  parameter int NDIG        = NDIG_DEF,
  parameter int BLANK_TICKS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  lr3_disp_scan_if.slave bus
);

  localparam logic [3:0]      BT       = 4'(BLANK_TICKS);
  localparam logic [2:0]      LAST_IDX = 3'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_ALL   = AN_OFF[NDIG-1:0];

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt, next_idx;
  logic [31:0]     act_r, pend_r, act_nxt;
  logic            pend_v;
  logic [NDIG-1:0] an_r, an_nxt;
  logic [6:0]      cat_r, cat_nxt, seg;
  logic            frm_r, frm_nxt;
  logic [3:0]      nib;
  logic            advance, frame_start, lead_zero, lit;

  lr3_hex7seg u_hex7seg (
    .nib (nib),
    .seg (seg)
  );

  always_comb begin
    advance = 1'b0;
    if (bus.disp_ce) begin
      if (state == ST_BLK && cnt == BT) advance = 1'b1;
      if (state == ST_ACT && BT == 4'd0) advance = 1'b1;
    end

    next_idx    = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    frame_start = advance && (next_idx == 3'd0);
    // The digit entered on a frame-start edge must already see the freshly transferred word
    act_nxt     = (frame_start && pend_v) ? pend_r : act_r;
    nib         = act_nxt[{next_idx, 2'b00} +: 4];

    lead_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if (j >= int'(next_idx) && act_nxt[4*j +: 4] != 4'h0) lead_zero = 1'b0;
    end
    lit = bus.en_mask[next_idx] && !(bus.lzb && next_idx != 3'd0 && lead_zero);

    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    an_nxt    = an_r;
    cat_nxt   = cat_r;
    frm_nxt   = 1'b0;

    if (advance) begin
      state_nxt = ST_ACT;
      idx_nxt   = next_idx;
      an_nxt    = lit ? ~(NDIG'(1) << next_idx) : AN_ALL;
      cat_nxt   = lit ? seg : CAT_OFF;
      frm_nxt   = (next_idx == 3'd0);
    end else if (bus.disp_ce) begin
      case (state)
        ST_ACT: begin
          state_nxt = ST_BLK;
          cnt_nxt   = 4'd1;
          an_nxt    = AN_ALL;
          cat_nxt   = CAT_OFF;
        end
        default: cnt_nxt = cnt + 4'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLK;
      cnt   <= BT;
      idx   <= LAST_IDX;
      an_r  <= AN_ALL;
      cat_r <= CAT_OFF;
      frm_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      an_r  <= an_nxt;
      cat_r <= cat_nxt;
      frm_r <= frm_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r  <= '0;
      pend_r <= '0;
      pend_v <= 1'b0;
    end else begin
      act_r <= act_nxt;
      if (bus.ld) begin
        pend_r <= bus.dat_i;
        pend_v <= 1'b1;
      end else if (frame_start && pend_v) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign bus.an      = an_r;
  assign bus.cat     = cat_r;
  assign bus.dig_idx = idx;
  assign bus.frm_o   = frm_r;

endmodule

`default_nettype wire

// File: tb/tb_lr3_disp_scan.sv
// tb_lr3_disp_scan: directed, table-driven bench for lr3_disp_scan (BLANK_TICKS=1 and 0).
// Rev 1.0
`default_nettype none

module tb_lr3_disp_scan;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mask;
    logic        lzb;
    logic [63:0] an_e;   // digit k expectation at [8k +: 8]
    logic [55:0] cat_e;  // digit k expectation at [7k +: 7]
  } vec_t;

  logic        clk, rst_n, disp_ce, ld, lzb;
  logic [31:0] dat;
  logic [7:0]  mask;
  int          checks = 0;
  int          errors = 0;

  lr3_disp_scan_if #(.NDIG(8)) bus1 ();
  lr3_disp_scan_if #(.NDIG(8)) bus0 ();

  assign bus1.disp_ce = disp_ce;  assign bus0.disp_ce = disp_ce;
  assign bus1.ld      = ld;       assign bus0.ld      = ld;
  assign bus1.dat_i   = dat;      assign bus0.dat_i   = dat;
  assign bus1.en_mask = mask;     assign bus0.en_mask = mask;
  assign bus1.lzb     = lzb;      assign bus0.lzb     = lzb;

  lr3_disp_scan #(.NDIG(8), .BLANK_TICKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lr3_disp_scan #(.NDIG(8), .BLANK_TICKS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) disp_ce = 1'b1;
    @(negedge clk) disp_ce = 1'b0;
  endtask

  task automatic tick_ld(input logic [31:0] d);
    @(negedge clk) begin disp_ce = 1'b1; ld = 1'b1; dat = d; end
    @(negedge clk) begin disp_ce = 1'b0; ld = 1'b0; end
  endtask

  task automatic load(input logic [31:0] d);
    @(negedge clk) begin ld = 1'b1; dat = d; end
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic run_to_frame(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus1.frm_o === 1'b1) got = 1'b1;
    end
    chk({tag, " frame start seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    mask = v.mask;
    lzb  = v.lzb;
    load(v.data);
    run_to_frame(tag);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick();
        chk($sformatf("%s blank%0d an", tag, k), 32'(bus1.an), 32'h0FF);
        chk($sformatf("%s blank%0d cat", tag, k), 32'(bus1.cat), 32'h07F);
        tick();
      end
      chk($sformatf("%s d%0d an", tag, k), 32'(bus1.an), 32'(v.an_e[8*k +: 8]));
      chk($sformatf("%s d%0d cat", tag, k), 32'(bus1.cat), 32'(v.cat_e[7*k +: 7]));
      chk($sformatf("%s d%0d idx", tag, k), 32'(bus1.dig_idx), 32'(k));
    end
  endtask

  vec_t tbl [5];
  logic [6:0] tear_cat [4];

  initial begin
    tbl[0] = '{32'h1234ABCD, 8'hFF, 1'b0,
               {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
               {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}};
    tbl[1] = '{32'h000000A5, 8'hFF, 1'b1,
               {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
    tbl[2] = '{32'h00000000, 8'hFF, 1'b1,
               {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[3] = '{32'h87654321, 8'hF0, 1'b0,
               {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
               {7'h00, 7'h78, 7'h02, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    tbl[4] = '{32'h00F00000, 8'hFF, 1'b1,
               {8'hFF, 8'hFF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
               {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tear_cat = '{7'h19, 7'h30, 7'h24, 7'h79};

    rst_n = 1'b0; disp_ce = 1'b0; ld = 1'b0; dat = '0; mask = 8'hFF; lzb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst an", 32'(bus1.an), 32'h0FF);
    chk("rst cat", 32'(bus1.cat), 32'h07F);
    chk("rst frm", 32'(bus1.frm_o), 32'd0);
    chk("rst idx", 32'(bus1.dig_idx), 32'd7);
    @(negedge clk) rst_n = 1'b1;

    tick();
    chk("first an", 32'(bus1.an), 32'h0FE);
    chk("first cat", 32'(bus1.cat), 32'h040);
    chk("first frm", 32'(bus1.frm_o), 32'd1);
    chk("bt0 first an", 32'(bus0.an), 32'h0FE);
    chk("bt0 first frm", 32'(bus0.frm_o), 32'd1);
    @(negedge clk);
    chk("frm one cycle", 32'(bus1.frm_o), 32'd0);
    tick();
    chk("first blank an", 32'(bus1.an), 32'h0FF);
    chk("first blank cat", 32'(bus1.cat), 32'h07F);
    chk("blank keeps idx", 32'(bus1.dig_idx), 32'd0);
    chk("bt0 direct an", 32'(bus0.an), 32'h0FD);
    chk("bt0 direct cat", 32'(bus0.cat), 32'h040);
    chk("bt0 direct idx", 32'(bus0.dig_idx), 32'd1);

    for (int r = 0; r < 5; r++) check_frame($sformatf("row%0d", r), tbl[r]);

    // Tearing: a load mid-frame must not reach the upper digits until the next frame
    mask = 8'hFF; lzb = 1'b0;
    load(32'h1234ABCD);
    run_to_frame("tear");
    repeat (6) tick();
    chk("tear d3 an", 32'(bus1.an), 32'h0F7);
    load(32'h11111111);
    for (int k = 4; k < 8; k++) begin
      tick(); tick();
      chk($sformatf("tear d%0d cat", k), 32'(bus1.cat), 32'(tear_cat[k-4]));
    end
    run_to_frame("tear next");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin tick(); tick(); end
      chk($sformatf("tear next d%0d cat", k), 32'(bus1.cat), 32'h079);
    end

    // Load coinciding with the frame-start edge is shown one frame later
    tick();
    tick_ld(32'h22222222);
    chk("ldfs frm", 32'(bus1.frm_o), 32'd1);
    chk("ldfs d0 cat", 32'(bus1.cat), 32'h079);
    repeat (14) tick();
    chk("ldfs d7 cat", 32'(bus1.cat), 32'h079);
    run_to_frame("ldfs next");
    chk("ldfs next d0 cat", 32'(bus1.cat), 32'h024);

    // Asynchronous reset in the middle of digit 5
    repeat (10) tick();
    chk("pre-rst d5 an", 32'(bus1.an), 32'h0DF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst an", 32'(bus1.an), 32'h0FF);
    chk("async rst cat", 32'(bus1.cat), 32'h07F);
    chk("async rst idx", 32'(bus1.dig_idx), 32'd7);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post-rst frm", 32'(bus1.frm_o), 32'd1);
    chk("post-rst an", 32'(bus1.an), 32'h0FE);
    chk("post-rst cat", 32'(bus1.cat), 32'h040);
    run_to_frame("post-rst next");
    chk("post-rst next cat", 32'(bus1.cat), 32'h040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/lr3_disp_scan.md
Name: lr3_disp_scan

Overview:
- Time-multiplexed driver for the 8-digit, 7-segment board display.
- Sits directly downstream of the lab-3 datapath. It consumes a 32-bit hex word (8 nibbles) plus a load strobe, and the DISP_CE tick from the display clock-enable generator.
- Drives the active-low CAT/AN pins.
- Adds:
  - frame-synchronous double buffering, so displayed values never tear;
  - a per-digit enable mask;
  - leading-zero blanking;
  - a configurable anti-ghosting blank interval between digits.

Parameters:
- NDIG, 8: number of digits scanned; AN width.
- BLANK_TICKS, 1: number of DISP_CE ticks with all anodes off between digits (0..15). 0 means no blank phase.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- DISP_CE  in  1  one-CLK-wide scan tick; all state advances only on CLK edges with DISP_CE=1.
- LD  in  1  load strobe; captures DAT_I into the pending buffer.
- DAT_I  in  32  nibble k drives digit k; digit 0 is the rightmost, AN[0].
- EN_MASK  in  NDIG  1 = digit k may light.
- LZB  in  1  1 = leading-zero blanking enabled.
- CAT  out  7  segments, active-low; CAT[0]=a … CAT[6]=g.
- AN  out  NDIG  anodes, active-low, one-hot-low when lit.
- DIG_IDX  out  3  index of the digit currently in its ACT phase (or last ACT digit during BLK).
- FRM_O  out  1  one-CLK pulse on the edge that starts digit 0 (frame start).

Behaviour:
- Reset (RST=0, asynchronous) sets:
  - AN=all 1, CAT=7'h7F, FRM_O=0;
  - state=BLK, blank counter expired, DIG_IDX=NDIG-1;
  - ACT_R=0, PEND_R=0, PEND_V=0.
- Reset applied mid-scan blanks the display immediately (no glitch-lit digit).
- Buffers:
  - LD=1 on an edge sets PEND_R<=DAT_I and PEND_V<=1. A repeated LD overwrites PEND_R.
  - At frame start, if PEND_V=1: ACT_R<=PEND_R and PEND_V<=0. Otherwise ACT_R is unchanged.
  - If LD coincides with frame start: the transfer uses PEND_R as it stood before the edge. The new DAT_I lands in PEND_R with PEND_V=1 and is shown next frame.
- FSM with states ACT and BLK; every transition below occurs only on DISP_CE=1.
  - BLK, with blank count reaching BLANK_TICKS (or BLANK_TICKS=0):
    - idx<=(idx==NDIG-1)?0:idx+1; state<=ACT;
    - AN and CAT are loaded for the new idx;
    - FRM_O=1 for that one edge when the new idx=0.
  - ACT: on the next DISP_CE, if BLANK_TICKS>0 go to BLK with AN=all 1, CAT=7F, counter=1. If BLANK_TICKS=0, advance directly as in the BLK exit.
  - BLK with count<BLANK_TICKS: count+1; outputs stay off.
- Digit lit rule, evaluated on ACT entry for digit k using ACT_R after any same-edge transfer:
  - lit = EN_MASK[k] AND NOT (LZB AND k!=0 AND nibbles k..NDIG-1 of ACT_R all zero);
  - digit 0 is never LZ-blanked.
  - EN_MASK and LZB are sampled only at that entry edge.
- Output values:
  - Lit: AN=~(1<<k), CAT=SEG_LUT[nibble k].
  - Unlit: AN=all 1, CAT=7F.
- All outputs are registered; latency is 1 CLK from the qualifying DISP_CE edge. There is no combinational path from inputs to pins.
- SEG_LUT (active-low, g..a):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Period: with D=DISP_CE period, each digit is lit for D and dark for BLANK_TICKS·D. Frame length is NDIG·(1+BLANK_TICKS)·D.

Decomposition:
- Package lr3_disp_pkg holds:
  - SEG_LUT constant array;
  - CAT_OFF=7'h7F and AN_OFF=all-ones constants;
  - the state enum {ACT, BLK};
  - default NDIG.
- One combinational sub-module, lr3_hex7seg (4-bit nibble in, 7-bit active-low segments out), instantiated once on the selected nibble.
- FSM, buffers and leading-zero logic stay in lr3_disp_scan.

Test Plan:
- Reset, no LD, BLANK_TICKS=1, EN_MASK=FF, LZB=0:
  - while reset is held, AN=FF, CAT=7F;
  - first DISP_CE gives AN=FE, CAT=40 and FRM_O=1 one cycle;
  - next DISP_CE gives AN=FF, CAT=7F.
- LD 0x1234ABCD then run one full frame: expect the lit sequence AN FE/21, FD/46, FB/03, F7/08, EF/19, DF/30, BF/24, 7F/79, with an FF/7F blank between each.
- Tearing: load 0x1234ABCD, then at digit 3 LD 0x11111111 → digits 4..7 still show 4,3,2,1. At the next FRM_O all digits show CAT=79. Also check LD on the frame-start edge → shown one frame later.
- LZB=1, data 0x000000A5 → AN FE/CAT 12 and AN FD/CAT 08 lit; digits 2..7 keep AN=FF. Data 0 → digit 0 shows CAT 40, all others dark.
- EN_MASK=F0, data 0x87654321 → digits 0-3 dark (AN=FF) in their slots; digits 4-7 show 5,6,7,8. Also run BLANK_TICKS=0 → AN steps FE→FD directly with no FF slot.
- Assert RST during the ACT of digit 5 → AN=FF and CAT=7F asynchronously. After release, the scan restarts at digit 0 with FRM_O and ACT_R=0 (CAT=40).
